noc_xbar_interconnect: RTL and testbench

//   N-port generalisation of the two-core FIFO link. Each core pushes {dest, data} into
//   its own ingress FIFO. A per-destination round-robin arbiter moves FIFO heads into a
//   one-entry egress register that the destination core reads with a valid/read handshake.

---
 rtl/noc_xbar_interconnect.sv | 130 +++++++++++++
 tb/tb_noc_xbar_interconnect.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_xbar_interconnect.sv
// rtl/noc_xbar_interconnect.sv - N-port crossbar: per-source ingress FIFOs, per-destination RR arbiters
// and one-entry egress registers with a valid/read handshake.
module noc_xbar_interconnect #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int OCUP_W  = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          wr_en,
  input  logic [N_CORES*ADDR_W-1:0]   wr_addr,
  input  logic [N_CORES*DATA_W-1:0]   wr_data,
  output logic [N_CORES-1:0]          full,
  output logic [N_CORES*OCUP_W-1:0]   ocup,
  output logic [N_CORES-1:0]          err,
  input  logic [N_CORES-1:0]          rd_en,
  output logic [N_CORES-1:0]          rd_valid,
  output logic [N_CORES*DATA_W-1:0]   rd_data,
  output logic [N_CORES*ADDR_W-1:0]   rd_src
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0]  mem_q   [N_CORES][DEPTH];
  logic [PTR_W-1:0]  wptr_q  [N_CORES];
  logic [PTR_W-1:0]  rptr_q  [N_CORES];
  logic [OCUP_W-1:0] cnt_q   [N_CORES];
  logic [N_CORES-1:0] err_q;
  logic [N_CORES-1:0] vld_q;
  logic [DATA_W-1:0] rdat_q  [N_CORES];
  logic [ADDR_W-1:0] rsrc_q  [N_CORES];
  logic [ADDR_W-1:0] rr_q    [N_CORES];

  logic [N_CORES-1:0] full_w, push_w, drop_w, pop_w, gnt_vld_w;
  logic [ADDR_W-1:0]  gnt_src_w [N_CORES];
  logic [ADDR_W-1:0]  head_dest_w [N_CORES];
  logic [DATA_W-1:0]  head_data_w [N_CORES];

  // Ingress acceptance uses the pre-edge full flag, so a same-cycle pop never frees room.
  always_comb begin
    full_w = '0;
    push_w = '0;
    drop_w = '0;
    for (int i = 0; i < N_CORES; i++) begin
      full_w[i] = (cnt_q[i] == OCUP_W'(DEPTH));
      push_w[i] = wr_en[i] && !full_w[i] && (int'(wr_addr[i*ADDR_W +: ADDR_W]) < N_CORES);
      drop_w[i] = wr_en[i] && !push_w[i];
      head_dest_w[i] = mem_q[i][rptr_q[i]][ENT_W-1 -: ADDR_W];
      head_data_w[i] = mem_q[i][rptr_q[i]][DATA_W-1:0];
    end
  end

  // Per-destination round-robin search starting one past the last granted source.
  always_comb begin
    int s;
    s         = 0;
    pop_w     = '0;
    gnt_vld_w = '0;
    for (int d = 0; d < N_CORES; d++) gnt_src_w[d] = '0;
    for (int d = 0; d < N_CORES; d++) begin
      if (!vld_q[d] || rd_en[d]) begin
        for (int k = 1; k <= N_CORES; k++) begin
          s = int'(rr_q[d]) + k;
          if (s >= N_CORES) s = s - N_CORES;
          if (!gnt_vld_w[d] && (cnt_q[s] != '0) && (head_dest_w[s] == ADDR_W'(d))) begin
            gnt_vld_w[d] = 1'b1;
            gnt_src_w[d] = ADDR_W'(s);
            pop_w[s]     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (push_w[i]) begin
        mem_q[i][wptr_q[i]] <= {wr_addr[i*ADDR_W +: ADDR_W], wr_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        rdat_q[i] <= '0;
        rsrc_q[i] <= '0;
        rr_q[i]   <= ADDR_W'(N_CORES - 1);
      end
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (push_w[i]) wptr_q[i] <= wptr_q[i] + PTR_W'(1);
        if (pop_w[i])  rptr_q[i] <= rptr_q[i] + PTR_W'(1);
        cnt_q[i] <= cnt_q[i] + OCUP_W'(push_w[i]) - OCUP_W'(pop_w[i]);
        if (drop_w[i]) err_q[i] <= 1'b1;
      end
      for (int d = 0; d < N_CORES; d++) begin
        if (gnt_vld_w[d]) begin
          vld_q[d]  <= 1'b1;
          rdat_q[d] <= head_data_w[gnt_src_w[d]];
          rsrc_q[d] <= gnt_src_w[d];
          rr_q[d]   <= gnt_src_w[d];
        end else if (rd_en[d]) begin
          vld_q[d] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    full    = full_w;
    err     = err_q;
    rd_valid = vld_q;
    ocup    = '0;
    rd_data = '0;
    rd_src  = '0;
    for (int i = 0; i < N_CORES; i++) begin
      ocup[i*OCUP_W +: OCUP_W]    = cnt_q[i];
      rd_data[i*DATA_W +: DATA_W] = rdat_q[i];
      rd_src[i*ADDR_W +: ADDR_W]  = rsrc_q[i];
    end
  end
endmodule

// File: tb/tb_noc_xbar_interconnect.sv
// tb/tb_noc_xbar_interconnect.sv - self-checking bench for noc_xbar_interconnect
// (4-core instance with a per source/destination scoreboard, plus a 3-core instance).
module tb_noc_xbar_interconnect;
  localparam int N = 4, AW = 2, DW = 32, DEPTH = 16, OW = 5, N3 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    wr_en, rd_en, full, err, rd_valid;
  logic [N*AW-1:0] wr_addr, rd_src;
  logic [N*DW-1:0] wr_data, rd_data;
  logic [N*OW-1:0] ocup;

  logic [N3-1:0]    wr_en3, rd_en3, full3, err3, rd_valid3;
  logic [N3*AW-1:0] wr_addr3, rd_src3;
  logic [N3*DW-1:0] wr_data3, rd_data3;
  logic [N3*OW-1:0] ocup3;

  noc_xbar_interconnect #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .OCUP_W(OW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .ocup(ocup), .err(err), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_src(rd_src));

  noc_xbar_interconnect #(.N_CORES(N3), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .OCUP_W(OW)) dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .full(full3), .ocup(ocup3), .err(err3), .rd_en(rd_en3), .rd_valid(rd_valid3),
    .rd_data(rd_data3), .rd_src(rd_src3));

  typedef struct {
    int          src;
    int          dst;
    logic [DW-1:0] data;
    logic [N-1:0]  exp_valid;
  } vec_t;

  logic [DW-1:0] sb_q [N*N][$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] ocup_of(input int i);
    return ocup[i*OW +: OW];
  endfunction
  function automatic logic [DW-1:0] rdat(input int d);
    return rd_data[d*DW +: DW];
  endfunction
  function automatic logic [AW-1:0] rsrc(input int d);
    return rd_src[d*AW +: AW];
  endfunction
  function automatic int sb_total();
    int t;
    t = 0;
    for (int i = 0; i < N*N; i++) t += sb_q[i].size();
    return t;
  endfunction

  task automatic set_wr(input int s, input int d, input logic [DW-1:0] data, input bit ok);
    wr_en[s] = 1'b1;
    wr_addr[s*AW +: AW] = AW'(d);
    wr_data[s*DW +: DW] = data;
    if (ok) sb_q[s*N+d].push_back(data);
  endtask

  // Words consumed at the coming edge are checked against the scoreboard first.
  task automatic tick();
    int s;
    logic [DW-1:0] e;
    for (int d = 0; d < N; d++) begin
      if (rd_en[d] && rd_valid[d]) begin
        s = int'(rsrc(d));
        if (sb_q[s*N+d].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: dest %0d got src %0d data 0x%0h, expected no word", d, s, rdat(d));
        end else begin
          e = sb_q[s*N+d].pop_front();
          chk("sb_data", rdat(d), e);
        end
      end
    end
    @(posedge clk);
    #1;
    wr_en = '0;
  endtask

  task automatic drain();
    rd_en = '1;
    for (int t = 0; t < 64; t++) begin
      if (sb_total() == 0 && rd_valid == '0) break;
      tick();
    end
    rd_en = '0;
    chk("drain_done", {63'd0, (sb_total() == 0 && rd_valid == '0)}, 64'd1);
  endtask

  task automatic do_reset();
    wr_en = '0;
    rd_en = '0;
    wr_en3 = '0;
    rd_en3 = '0;
    reset = 1'b0;
    for (int i = 0; i < N*N; i++) sb_q[i].delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int ord[3];
    vt[0] = '{0, 2, 32'hDEADBEEF, 4'b0100};
    vt[1] = '{1, 0, 32'h11110000, 4'b0001};
    vt[2] = '{3, 3, 32'h33333333, 4'b1000};
    vt[3] = '{2, 1, 32'h2222AAAA, 4'b0010};
    vt[4] = '{3, 0, 32'h30303030, 4'b0001};
    vt[5] = '{1, 1, 32'h0000FFFF, 4'b0010};
    ord = '{0, 1, 3};

    wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '0;
    wr_en3 = '0; wr_addr3 = '0; wr_data3 = '0; rd_en3 = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ocup", ocup, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_data", |rd_data, 0);
    chk("rst_rd_src", rd_src, 0);
    chk("rst3_ocup", ocup3, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rd_valid", rd_valid, 0);

    // Single transfers: 2-cycle latency, one-hot rd_valid, FIFO back to empty.
    for (int i = 0; i < 6; i++) begin
      set_wr(vt[i].src, vt[i].dst, vt[i].data, 1'b1);
      tick();
      chk("vec_ocup_pending", ocup_of(vt[i].src), 1);
      chk("vec_valid_early", rd_valid, 0);
      tick();
      chk("vec_valid", rd_valid, vt[i].exp_valid);
      chk("vec_data", rdat(vt[i].dst), vt[i].data);
      chk("vec_src", rsrc(vt[i].dst), vt[i].src);
      chk("vec_ocup_empty", ocup_of(vt[i].src), 0);
      rd_en[vt[i].dst] = 1'b1;
      tick();
      rd_en = '0;
      chk("vec_consumed", rd_valid, 0);
    end

    // Round robin from reset pointer, then continuous flood from two sources.
    do_reset();
    set_wr(0, 1, 32'h100, 1'b1);
    set_wr(1, 1, 32'h101, 1'b1);
    set_wr(3, 1, 32'h103, 1'b1);
    rd_en[1] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_order", rsrc(1), ord[k]);
    end
    tick();
    chk("rr_idle", rd_valid, 0);
    for (int c = 0; c < 10; c++) begin
      set_wr(0, 1, 32'h2000 + c, 1'b1);
      set_wr(1, 1, 32'h3000 + c, 1'b1);
      tick();
      if (c >= 1) chk("rr_alternate", rsrc(1), (c - 1) % 2);
    end
    drain();

    // Fill to full with egress stalled; 18th write dropped.
    do_reset();
    for (int w = 1; w <= 18; w++) begin
      set_wr(0, 2, 32'hA000 + w, w <= 17);
      tick();
      if (w == 1) chk("fill_ocup_1", ocup_of(0), 1);
      if (w == 17) begin
        chk("fill_full", full[0], 1);
        chk("fill_ocup_16", ocup_of(0), 16);
        chk("fill_err_clear", err[0], 0);
      end
    end
    chk("overflow_err", err[0], 1);
    chk("overflow_ocup", ocup_of(0), 16);
    chk("overflow_egress", rdat(2), 32'hA001);
    drain();

    // Invalid destination on a 3-core crossbar, then the highest valid one.
    do_reset();
    wr_en3[1] = 1'b1;
    wr_addr3[1*AW +: AW] = 2'd3;
    wr_data3[1*DW +: DW] = 32'hBADBAD00;
    @(posedge clk);
    #1 wr_en3 = '0;
    chk("bad_dest_err", err3, 3'b010);
    chk("bad_dest_ocup", ocup3[1*OW +: OW], 0);
    @(posedge clk);
    #1;
    chk("bad_dest_no_valid", rd_valid3, 0);
    wr_en3[1] = 1'b1;
    wr_addr3[1*AW +: AW] = 2'd2;
    wr_data3[1*DW +: DW] = 32'h0C0FFEE0;
    @(posedge clk);
    #1 wr_en3 = '0;
    @(posedge clk);
    #1;
    chk("dest2_valid3", rd_valid3, 3'b100);
    chk("dest2_data3", rd_data3[2*DW +: DW], 32'h0C0FFEE0);
    chk("dest2_src3", rd_src3[2*AW +: AW], 1);

    // Head-of-line blocking: src0 dest2 word waits behind stalled dest1 word.
    do_reset();
    set_wr(1, 1, 32'hC001, 1'b1);
    tick();
    tick();
    chk("hol_egress1", rd_valid, 4'b0010);
    set_wr(0, 1, 32'hC100, 1'b1);
    tick();
    set_wr(0, 2, 32'hC200, 1'b1);
    tick();
    tick();
    tick();
    chk("hol_blocked", rd_valid[2], 0);
    chk("hol_ocup", ocup_of(0), 2);
    chk("hol_stable_src", rsrc(1), 1);
    chk("hol_stable_data", rdat(1), 32'hC001);
    rd_en[1] = 1'b1;
    tick();
    rd_en = '0;
    chk("hol_still_blocked", rd_valid[2], 0);
    chk("hol_next_src", rsrc(1), 0);
    chk("hol_next_data", rdat(1), 32'hC100);
    tick();
    chk("hol_released", rd_valid[2], 1);
    chk("hol_released_data", rdat(2), 32'hC200);
    drain();

    // Full FIFO with pop and write in the same cycle, then async reset mid-run.
    do_reset();
    for (int w = 1; w <= 17; w++) begin
      set_wr(0, 2, 32'hB000 + w, 1'b1);
      tick();
    end
    chk("pw_full", full[0], 1);
    chk("pw_err_clear", err[0], 0);
    rd_en[2] = 1'b1;
    set_wr(0, 2, 32'hBBAD, 1'b0);
    tick();
    rd_en = '0;
    chk("pw_err", err[0], 1);
    chk("pw_ocup", ocup_of(0), DEPTH - 1);
    chk("pw_egress", rdat(2), 32'hB002);
    set_wr(0, 2, 32'hB0FF, 1'b1);
    tick();
    chk("pw_refull", full[0], 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_ocup", ocup, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_err", err, 0);
    for (int i = 0; i < N*N; i++) sb_q[i].delete();
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("after_rst_rd_valid", rd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
